// File: rtl/cache_writeback_buffer_pkg.sv
// ---------------------------------------------------------------------------
// lc3b_types: shared types for the L1 write-back buffer slice.
//   lc3b_line_addr : 12-bit line address (byte address bits [15:4])
//   lc3b_line      : one 128-bit cache line
//   wb_entry       : one buffer slot {valid, line_addr, line}
//   wb_state_t     : downstream memory-port FSM state
// ---------------------------------------------------------------------------
package lc3b_types;

  typedef logic [11:0]  lc3b_line_addr;
  typedef logic [127:0] lc3b_line;

  typedef struct packed {
    logic          valid;
    lc3b_line_addr line_addr;
    lc3b_line      line;
  } wb_entry;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_READ  = 2'd1,
    WB_WRITE = 2'd2,
    WB_RESP  = 2'd3
  } wb_state_t;

  // Strip the byte offset from a 16-bit byte address.
  function automatic lc3b_line_addr line_addr_of(input logic [15:0] addr);
    return addr[15:4];
  endfunction

endpackage

// File: rtl/wb_match.sv
// ---------------------------------------------------------------------------
// wb_match: combinational CAM over the write-back buffer entries.
// Only instantiated when WB_FORWARD_EN is defined.
//
// Ports:
//   entries     in   all buffer slots (packed, index = slot number)
//   head        in   slot index of the oldest entry
//   count       in   number of occupied slots
//   draining    in   head slot is currently being written to memory
//   query       in   line address to look up
//   hit         out  some occupied, valid slot matches query
//   hit_idx     out  slot index of the youngest matching entry
//   hit_line    out  line data held in slot hit_idx
//   coalesce_ok out  a write to query may overwrite slot hit_idx in place
// ---------------------------------------------------------------------------
module wb_match
  import lc3b_types::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH)
) (
  input  wb_entry [DEPTH-1:0] entries,
  input  logic    [PW-1:0]    head,
  input  logic    [PW:0]      count,
  input  logic                draining,
  input  lc3b_line_addr       query,
  output logic                hit,
  output logic    [PW-1:0]    hit_idx,
  output lc3b_line            hit_line,
  output logic                coalesce_ok
);

  logic [PW-1:0] idx;

  // Walk from oldest to youngest so a later match overrides an earlier one;
  // the surviving index is therefore the youngest matching entry.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (((PW+1)'(k) < count) && entries[idx].valid &&
          (entries[idx].line_addr == query)) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

  assign hit_line = entries[hit_idx].line;

  // The head slot is frozen while memory is being written from it, so a
  // matching write must not land there.
  assign coalesce_ok = hit && !(draining && (hit_idx == head));

endmodule

// File: rtl/cache_writeback_buffer.sv
// ---------------------------------------------------------------------------
// cache_writeback_buffer: eviction buffer between the L1 cache memory port
// and physical memory. Dirty-line write-backs are absorbed in one cycle and
// drained to memory in FIFO order whenever no read is waiting.
//
// Build option WB_FORWARD_EN:
//   defined   - read misses that match a buffered line are served from the
//               buffer, writes to a buffered (non-draining) line coalesce,
//               and a waiting read miss takes priority over draining.
//   undefined - no address compare; every write allocates, reads go to
//               memory only once the buffer is empty.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   pmem_read/_write   cache request strobes, held until pmem_resp
//   pmem_address       cache line address (bits [3:0] ignored)
//   pmem_wdata         eviction line
//   pmem_rdata         registered read line to the cache
//   pmem_resp          one-cycle completion pulse to the cache
//   phys_read/_write   memory strobes, held until phys_resp
//   phys_address       memory line address (bits [3:0] zero)
//   phys_wdata         line being drained
//   phys_rdata         memory read line
//   phys_resp          memory completion pulse
//   wb_empty, wb_full  occupancy flags
//
// Downstream FSM
//   state    | meaning
//   WB_IDLE  | choose between a pending read miss and draining the head
//   WB_READ  | memory read for the cache's miss in flight
//   WB_WRITE | head entry being written to memory
//   WB_RESP  | read-miss data returned, pmem_resp high this cycle
// ---------------------------------------------------------------------------
module cache_writeback_buffer
  import lc3b_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         phys_read,
  output logic         phys_write,
  output logic [15:0]  phys_address,
  output logic [127:0] phys_wdata,
  input  logic [127:0] phys_rdata,
  input  logic         phys_resp,
  output logic         wb_empty,
  output logic         wb_full
);

  localparam int PW = $clog2(DEPTH);

  wb_entry [DEPTH-1:0] entries;
  logic    [PW-1:0]    head;
  logic    [PW-1:0]    tail;
  logic    [PW:0]      count;
  wb_state_t           state;
  wb_state_t           state_nxt;
  logic                ack_q;

  lc3b_line_addr query;
  logic          ack_pending;
  logic          draining;
  logic          drain_done;
  logic          wr_accept;
  logic          alloc;
  logic          coalesce;
  logic          rd_req;
  logic          rd_hit;
  logic          rd_miss;
  lc3b_line      fwd_line;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^pmem_address[3:0];

  assign query    = line_addr_of(pmem_address);
  assign wb_empty = (count == '0);
  assign wb_full  = (count == (PW+1)'(DEPTH));

  // pmem_resp comes either from a one-cycle write/hit acknowledge or from the
  // RESP state. While it is high the cache still holds its request, so the
  // same request must not be taken a second time.
  assign pmem_resp   = ack_q | (state == WB_RESP);
  assign ack_pending = pmem_resp;

  assign draining   = (state == WB_WRITE);
  assign drain_done = draining && phys_resp;

  // A full buffer may still accept on the edge that frees the head slot.
  assign wr_accept = pmem_write && !ack_pending && (!wb_full || drain_done);

  // Write has priority when both strobes are seen together.
  assign rd_req = pmem_read && !pmem_write && !ack_pending;

`ifdef WB_FORWARD_EN
  logic          hit;
  logic [PW-1:0] hit_idx;
  logic          coalesce_ok;

  wb_match #(.DEPTH(DEPTH)) u_match (
    .entries     (entries),
    .head        (head),
    .count       (count),
    .draining    (draining),
    .query       (query),
    .hit         (hit),
    .hit_idx     (hit_idx),
    .hit_line    (fwd_line),
    .coalesce_ok (coalesce_ok)
  );

  assign coalesce = wr_accept && coalesce_ok;
  assign alloc    = wr_accept && !coalesce_ok;
  assign rd_hit   = rd_req && hit && (state != WB_READ) && (state != WB_RESP);
  assign rd_miss  = rd_req && !hit;
`else
  assign fwd_line = '0;
  assign coalesce = 1'b0;
  assign alloc    = wr_accept;
  assign rd_hit   = 1'b0;
  assign rd_miss  = rd_req;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      WB_IDLE: begin
`ifdef WB_FORWARD_EN
        if (rd_miss)        state_nxt = WB_READ;
        else if (!wb_empty) state_nxt = WB_WRITE;
`else
        // Without forwarding memory could return stale data for a line
        // still sitting in the buffer, so reads wait for a full drain.
        if (!wb_empty)      state_nxt = WB_WRITE;
        else if (rd_miss)   state_nxt = WB_READ;
`endif
      end
      WB_READ:  if (phys_resp) state_nxt = WB_RESP;
      WB_WRITE: if (phys_resp) state_nxt = WB_IDLE;
      WB_RESP:  state_nxt = WB_IDLE;
      default:  state_nxt = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= WB_IDLE;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      ack_q      <= 1'b0;
      pmem_rdata <= '0;
      entries    <= '0;
    end else begin
      state <= state_nxt;
      ack_q <= wr_accept | rd_hit;

      if (rd_hit)
        pmem_rdata <= fwd_line;
      else if ((state == WB_READ) && phys_resp)
        pmem_rdata <= phys_rdata;

      // When full, tail equals head; the allocation below is written after
      // the valid clear so it wins on a simultaneous drain-and-accept.
      if (drain_done) begin
        entries[head].valid <= 1'b0;
        head                <= head + PW'(1);
      end

      if (alloc) begin
        entries[tail].valid     <= 1'b1;
        entries[tail].line_addr <= query;
        entries[tail].line      <= pmem_wdata;
        tail                    <= tail + PW'(1);
      end
`ifdef WB_FORWARD_EN
      else if (coalesce) begin
        entries[hit_idx].line <= pmem_wdata;
      end
`endif

      case ({alloc, drain_done})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    phys_read    = 1'b0;
    phys_write   = 1'b0;
    phys_address = '0;
    phys_wdata   = '0;
    case (state)
      WB_READ: begin
        phys_read    = 1'b1;
        phys_address = {query, 4'h0};
      end
      WB_WRITE: begin
        phys_write   = 1'b1;
        phys_address = {entries[head].line_addr, 4'h0};
        phys_wdata   = entries[head].line;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_writeback_buffer.sv
module tb_cache_writeback_buffer;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         pmem_read = 1'b0;
  logic         pmem_write = 1'b0;
  logic [15:0]  pmem_address = '0;
  logic [127:0] pmem_wdata = '0;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic         phys_read;
  logic         phys_write;
  logic [15:0]  phys_address;
  logic [127:0] phys_wdata;
  logic [127:0] phys_rdata = '0;
  logic         phys_resp = 1'b0;
  logic         wb_empty;
  logic         wb_full;

  always #5 clk = ~clk;

  cache_writeback_buffer #(.DEPTH(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .phys_read    (phys_read),
    .phys_write   (phys_write),
    .phys_address (phys_address),
    .phys_wdata   (phys_wdata),
    .phys_rdata   (phys_rdata),
    .phys_resp    (phys_resp),
    .wb_empty     (wb_empty),
    .wb_full      (wb_full)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Memory model: stores written lines, returns a pattern for untouched lines.
  logic [127:0] mem [logic [15:0]];
  logic         mem_hold = 1'b0;
  int           mem_lat  = 1;
  int           busy     = 0;
  int           seq      = 0;
  int           rd_strobe_cycles = 0;
  logic [15:0]  wr_addr [$];
  logic [127:0] wr_data [$];
  int           wr_seq  [$];
  logic [15:0]  rd_addr [$];
  int           rd_seq  [$];

  localparam logic [127:0] L_A  = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
  localparam logic [127:0] L_1  = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
  localparam logic [127:0] L_2  = 128'h2222_2222_2222_2222_2222_2222_2222_2222;
  localparam logic [127:0] L_3  = 128'h3333_3333_3333_3333_3333_3333_3333_3333;
  localparam logic [127:0] L_X  = 128'h7070_7070_7070_7070_7070_7070_7070_7070;
  localparam logic [127:0] L_B  = 128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB;
  localparam logic [127:0] L_C  = 128'hCCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC;
  localparam logic [127:0] L_E  = 128'hEEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE;
  localparam logic [127:0] L_F  = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;

  function automatic logic [127:0] pat(input logic [15:0] a);
    return {8{a}} ^ 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  endfunction

  always begin
    @(posedge clk);
    #1;
    if (phys_read) rd_strobe_cycles++;
    if (phys_resp) begin
      phys_resp = 1'b0;
    end else if (!reset_n || !(phys_read || phys_write)) begin
      busy = 0;
    end else if (!mem_hold) begin
      busy++;
      if (busy >= mem_lat) begin
        busy = 0;
        seq++;
        phys_resp = 1'b1;
        if (phys_write) begin
          mem[phys_address] = phys_wdata;
          wr_addr.push_back(phys_address);
          wr_data.push_back(phys_wdata);
          wr_seq.push_back(seq);
        end else begin
          phys_rdata = mem.exists(phys_address) ? mem[phys_address] : pat(phys_address);
          rd_addr.push_back(phys_address);
          rd_seq.push_back(seq);
        end
      end
    end
  end

  task automatic do_write(input logic [15:0] a, input logic [127:0] d, input int max, output int lat);
    pmem_address = a;
    pmem_wdata   = d;
    pmem_write   = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!pmem_resp && lat < max);
    if (!pmem_resp) lat = -1;
    pmem_write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [15:0] a, input int max, output logic [127:0] d, output int lat);
    pmem_address = a;
    pmem_read    = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!pmem_resp && lat < max);
    if (!pmem_resp) lat = -1;
    d = pmem_rdata;
    pmem_read = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_empty(input string name);
    int c = 0;
    while (!(wb_empty && !phys_write && !phys_read && !phys_resp) && c < 100) begin
      @(posedge clk); #1; c++;
    end
    n_checks++;
    if (!(wb_empty && !phys_write)) $display("FAIL %s_drain: wb_empty=%b phys_write=%b want 1/0", name, wb_empty, phys_write);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (pmem_resp !== 1'b0) $display("FAIL reset_pmem_resp: got %b want 0", pmem_resp); else n_pass++;
    n_checks++; if (phys_read !== 1'b0) $display("FAIL reset_phys_read: got %b want 0", phys_read); else n_pass++;
    n_checks++; if (phys_write !== 1'b0) $display("FAIL reset_phys_write: got %b want 0", phys_write); else n_pass++;
    n_checks++; if (phys_address !== 16'h0) $display("FAIL reset_phys_address: got %h want 0", phys_address); else n_pass++;
    n_checks++; if (pmem_rdata !== 128'h0) $display("FAIL reset_pmem_rdata: got %h want 0", pmem_rdata); else n_pass++;
    n_checks++; if (wb_empty !== 1'b1) $display("FAIL reset_wb_empty: got %b want 1", wb_empty); else n_pass++;
    n_checks++; if (wb_full !== 1'b0) $display("FAIL reset_wb_full: got %b want 0", wb_full); else n_pass++;
  endtask

  task automatic test_read_after_write();
    int lat_w, lat_r, rs0, nr0;
    logic [127:0] d;
    mem_hold = 1'b0;
    mem_lat  = 3;
    rs0 = rd_strobe_cycles;
    nr0 = rd_addr.size();
    do_write(16'h1230, L_A, 10, lat_w);
    n_checks++; if (lat_w !== 1) $display("FAIL raw_write_latency: got %0d want 1", lat_w); else n_pass++;
    do_read(16'h1230, 40, d, lat_r);
    n_checks++; if (d !== L_A) $display("FAIL raw_rdata: got %h want %h", d, L_A); else n_pass++;
`ifdef WB_FORWARD_EN
    n_checks++; if (lat_r !== 1) $display("FAIL raw_hit_latency: got %0d want 1", lat_r); else n_pass++;
    n_checks++; if (rd_strobe_cycles !== rs0) $display("FAIL raw_no_phys_read: got %0d read cycles want 0", rd_strobe_cycles - rs0); else n_pass++;
    wait_empty("raw");
`else
    n_checks++; if (rd_addr.size() !== nr0 + 1) $display("FAIL raw_phys_read_count: got %0d want %0d", rd_addr.size(), nr0 + 1); else n_pass++;
    n_checks++;
    if (rd_addr.size() == 0 || wr_seq.size() == 0 || !(wr_seq[$] < rd_seq[$]))
      $display("FAIL raw_write_before_read: write_seq=%0d read_seq=%0d want write first",
               (wr_seq.size() > 0) ? wr_seq[$] : -1, (rd_seq.size() > 0) ? rd_seq[$] : -1);
    else n_pass++;
`endif
  endtask

  task automatic test_full_stall();
    int lat, n0, c, resp_seen;
    logic edge_resp;
    logic [15:0]  exp_a [3];
    logic [127:0] exp_d [3];
    exp_a = '{16'h0010, 16'h0020, 16'h0030};
    exp_d = '{L_1, L_2, L_3};
    n0 = wr_addr.size();
    mem_hold = 1'b1;
    do_write(16'h0010, L_1, 10, lat);
    n_checks++; if (lat !== 1) $display("FAIL full_w1_latency: got %0d want 1", lat); else n_pass++;
    do_write(16'h0020, L_2, 10, lat);
    n_checks++; if (lat !== 1) $display("FAIL full_w2_latency: got %0d want 1", lat); else n_pass++;
    n_checks++; if (wb_full !== 1'b1) $display("FAIL full_flag: got %b want 1", wb_full); else n_pass++;
    n_checks++; if (phys_write !== 1'b1 || phys_address !== 16'h0010)
      $display("FAIL full_drain_head: got write=%b addr=%h want 1/0010", phys_write, phys_address); else n_pass++;
    pmem_address = 16'h0030;
    pmem_wdata   = L_3;
    pmem_write   = 1'b1;
    resp_seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (pmem_resp) resp_seen++;
    end
    n_checks++; if (resp_seen !== 0) $display("FAIL full_stall: got %0d resp pulses want 0", resp_seen); else n_pass++;
    mem_lat  = 1;
    mem_hold = 1'b0;
    c = 0;
    edge_resp = 1'b0;
    do begin
      @(posedge clk); edge_resp = phys_resp; #1; c++;
    end while (!pmem_resp && c < 20);
    n_checks++; if (!(pmem_resp && edge_resp))
      $display("FAIL full_accept_on_drain: got resp=%b phys_resp_at_edge=%b want 1/1", pmem_resp, edge_resp); else n_pass++;
    n_checks++; if (wb_full !== 1'b1) $display("FAIL full_count_kept: got wb_full=%b want 1", wb_full); else n_pass++;
    pmem_write = 1'b0;
    @(posedge clk); #1;
    wait_empty("full");
    n_checks++; if (wr_addr.size() !== n0 + 3) $display("FAIL full_write_count: got %0d want %0d", wr_addr.size() - n0, 3); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (n0 + i >= wr_addr.size() || wr_addr[n0+i] !== exp_a[i] || wr_data[n0+i] !== exp_d[i])
        $display("FAIL full_order_%0d: got addr=%h want %h", i,
                 (n0 + i < wr_addr.size()) ? wr_addr[n0+i] : 16'hxxxx, exp_a[i]);
      else n_pass++;
    end
  endtask

  task automatic test_coalesce();
    int lat, n0, c;
    n0 = wr_addr.size();
    mem_hold = 1'b1;
    do_write(16'h0070, L_X, 10, lat);
    n_checks++; if (lat !== 1) $display("FAIL coal_w1_latency: got %0d want 1", lat); else n_pass++;
    do_write(16'h0040, L_B, 10, lat);
    n_checks++; if (lat !== 1) $display("FAIL coal_wb_latency: got %0d want 1", lat); else n_pass++;
    pmem_address = 16'h0040;
    pmem_wdata   = L_C;
    pmem_write   = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_lat  = 1;
    mem_hold = 1'b0;
    c = 0;
    do begin @(posedge clk); #1; c++; end while (!pmem_resp && c < 20);
    n_checks++; if (pmem_resp !== 1'b1) $display("FAIL coal_accept: got resp=%b want 1", pmem_resp); else n_pass++;
`ifdef WB_FORWARD_EN
    n_checks++; if (wb_full !== 1'b0 || wb_empty !== 1'b0)
      $display("FAIL coal_count_one: got full=%b empty=%b want 0/0", wb_full, wb_empty); else n_pass++;
`else
    n_checks++; if (wb_full !== 1'b1) $display("FAIL coal_alloc_full: got full=%b want 1", wb_full); else n_pass++;
`endif
    pmem_write = 1'b0;
    @(posedge clk); #1;
    wait_empty("coal");
`ifdef WB_FORWARD_EN
    n_checks++;
    if (wr_addr.size() !== n0 + 2 || wr_addr[n0] !== 16'h0070 || wr_addr[n0+1] !== 16'h0040 || wr_data[n0+1] !== L_C)
      $display("FAIL coal_mem_seq: got %0d writes want 2 (0070, 0040=C)", wr_addr.size() - n0);
    else n_pass++;
`else
    n_checks++;
    if (wr_addr.size() !== n0 + 3 || wr_data[n0+1] !== L_B || wr_data[n0+2] !== L_C)
      $display("FAIL coal_mem_seq: got %0d writes want 3 (0070, 0040=B, 0040=C)", wr_addr.size() - n0);
    else n_pass++;
`endif
  endtask

  task automatic test_read_waits_drain();
    int lat, c;
    mem_hold = 1'b1;
    do_write(16'h0050, L_E, 10, lat);
    n_checks++; if (lat !== 1) $display("FAIL rwd_write_latency: got %0d want 1", lat); else n_pass++;
    pmem_address = 16'h0900;
    pmem_read    = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if (phys_read !== 1'b0) $display("FAIL rwd_read_blocked: got phys_read=%b want 0", phys_read); else n_pass++;
    n_checks++; if (phys_write !== 1'b1 || phys_address !== 16'h0050)
      $display("FAIL rwd_write_held: got write=%b addr=%h want 1/0050", phys_write, phys_address); else n_pass++;
    mem_lat  = 2;
    mem_hold = 1'b0;
    c = 0;
    do begin @(posedge clk); #1; c++; end while (!pmem_resp && c < 30);
    n_checks++; if (pmem_resp !== 1'b1) $display("FAIL rwd_resp: got resp=%b want 1", pmem_resp); else n_pass++;
    n_checks++; if (pmem_rdata !== pat(16'h0900)) $display("FAIL rwd_rdata: got %h want %h", pmem_rdata, pat(16'h0900)); else n_pass++;
    n_checks++;
    if (rd_addr.size() == 0 || wr_addr.size() == 0 || rd_addr[$] !== 16'h0900 || wr_addr[$] !== 16'h0050 || !(wr_seq[$] < rd_seq[$]))
      $display("FAIL rwd_order: got last read %h last write %h want 0900 after 0050",
               (rd_addr.size() > 0) ? rd_addr[$] : 16'hxxxx, (wr_addr.size() > 0) ? wr_addr[$] : 16'hxxxx);
    else n_pass++;
    pmem_read = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_write();
    int lat, nw0, nr0;
    logic [127:0] d;
    mem_hold = 1'b1;
    nw0 = wr_addr.size();
    do_write(16'h0080, L_F, 10, lat);
    @(posedge clk); #1;
    n_checks++; if (phys_write !== 1'b1) $display("FAIL rst_mid_active: got phys_write=%b want 1", phys_write); else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (phys_write !== 1'b0) $display("FAIL rst_mid_phys_write: got %b want 0", phys_write); else n_pass++;
    n_checks++; if (wb_empty !== 1'b1) $display("FAIL rst_mid_empty: got %b want 1", wb_empty); else n_pass++;
    @(posedge clk); #1;
    reset_n  = 1'b1;
    mem_lat  = 1;
    mem_hold = 1'b0;
    nr0 = rd_addr.size();
    do_read(16'h0080, 30, d, lat);
    n_checks++; if (d !== pat(16'h0080)) $display("FAIL rst_mid_rdata: got %h want %h", d, pat(16'h0080)); else n_pass++;
    n_checks++; if (rd_addr.size() !== nr0 + 1) $display("FAIL rst_mid_phys_read: got %0d reads want 1", rd_addr.size() - nr0); else n_pass++;
    n_checks++; if (wr_addr.size() !== nw0) $display("FAIL rst_mid_lost_line: got %0d writes want 0", wr_addr.size() - nw0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_read_after_write();
    test_full_stall();
    test_coalesce();
    test_read_waits_drain();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_writeback_buffer.md
# cache_writeback_buffer

Eviction buffer between the L1 cache's physical-memory port and physical memory. It absorbs dirty-line write-backs in one cycle so the cache can refill without waiting on the memory write. It forwards buffered lines to read misses that match them. It drains entries to memory in FIFO order whenever no read is waiting.

## Interface
Parameters:
- DEPTH, 2: number of line entries; a power of two, minimum 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pmem_read  in  1  cache line-read request; held high until pmem_resp.
- pmem_write  in  1  cache line-write (eviction) request; held high until pmem_resp.
- pmem_address  in  16  line address; bits [3:0] are ignored.
- pmem_wdata  in  128  eviction line.
- pmem_rdata  out  128  read line, registered.
- pmem_resp  out  1  one-cycle completion pulse to the cache.
- phys_read  out  1  memory read strobe.
- phys_write  out  1  memory write strobe.
- phys_address  out  16  memory address; bits [3:0] are always 0.
- phys_wdata  out  128  line being drained.
- phys_rdata  in  128  memory read line.
- phys_resp  in  1  memory completion pulse.
- wb_empty  out  1  no valid entries.
- wb_full  out  1  count equals DEPTH.

## Operation
- Entry = {valid, line_addr[15:4], line}. Entries are kept in a circular FIFO with head/tail pointers and a count of width clog2(DEPTH)+1.
- Write accept: requires pmem_write high, no ack pending, and the buffer not full.
  - If a valid entry other than the draining head has the same line_addr, the write overwrites that entry's data (coalesce). No allocation occurs.
  - Otherwise the write allocates at the tail.
  - pmem_resp pulses on the next cycle.
  - When the buffer is full, the write stalls until the drain completes. The same cycle phys_resp frees the head, the write may be accepted.
- Read hit: pmem_read matches a valid entry. On multiple matches, the youngest entry wins. pmem_rdata is loaded with that line and pmem_resp pulses on the next cycle. No memory access occurs. A read matching the head while it is draining still hits.
- Read miss: the downstream FSM issues phys_read. On phys_resp, phys_rdata is captured into pmem_rdata and pmem_resp pulses on the following cycle.
- ack_pending is set on any pmem_resp cycle. It blocks re-accepting the still-asserted request in that cycle.
- Downstream FSM states:
  - IDLE:
    - Pending read miss → READ. Reads have priority over drain.
    - Otherwise, if not empty → WRITE.
  - READ: phys_read=1 and phys_address={pmem_address[15:4],4'h0}. On phys_resp → RESP.
  - WRITE: phys_write=1 and address/data taken from the head. On phys_resp: head increments, count decrements, → IDLE.
  - RESP: one cycle. Drives pmem_resp. → IDLE.
- A phys operation, once started, holds address, data and strobe stable until phys_resp. It is never aborted except by reset.
- Simultaneous write accept and drain completion in one cycle: count is unchanged. Head and tail both advance.
- Pointers wrap modulo DEPTH.
- pmem_read and pmem_write are never high together. If both are high, pmem_write is serviced first.

## Timing
- Reset values:
  - All outputs 0.
  - wb_empty=1.
  - FSM=IDLE.
  - All entries invalid; pointers and count 0.
- Asserting reset_n low mid-operation drops phys_read and phys_write immediately. Buffered lines are lost.
- Write-accept latency: pmem_resp at T+1 after the accepting edge.
- Read-hit latency: 1 cycle.
- Read-miss latency: the phys_resp cycle plus 1. Add the remaining drain time if memory is mid-write.
- wb_full and wb_empty are registered-state decodes valid in the same cycle as count.

## Configuration
- WB_FORWARD_EN defined: read-hit forwarding and write coalescing as above.
- WB_FORWARD_EN undefined:
  - No address compare logic.
  - Every write allocates a new entry.
  - A read waits until wb_empty=1, then goes to memory. IDLE prefers WRITE over READ while the buffer is not empty.

## Structure
- lc3b_types package additions:
  - lc3b_line_addr (12-bit).
  - wb_entry struct.
  - wb_state_t enum (IDLE, READ, WRITE, RESP).
- One sub-module, wb_match: a combinational CAM. Inputs: entries, head, count, draining flag, query address. Outputs: hit, youngest hit index, coalesce-eligible flag. It is instantiated only under WB_FORWARD_EN.

## Test plan
- Write 0x1230 line A, then read 0x1230 → pmem_resp at T+1 with rdata=A; no phys_read.
- DEPTH=2: write 0x0010 and 0x0020, then a third write to 0x0030 → wb_full=1; the third write stalls until the first phys_resp; memory receives 0x0010 then 0x0020.
- Write 0x0040 (B), then write 0x0040 (C) while the head is not draining → count=1; memory later receives C only.
- Buffer holds 0x0050 with drain started, read miss to 0x0900 → the read waits for the write's phys_resp, then phys_read of 0x0900; pmem_rdata equals phys_rdata.
- Deassert reset_n mid-WRITE → phys_write=0 the same cycle; wb_empty=1; after release, a read to the old address goes to memory.
- Build without WB_FORWARD_EN, write 0x0060 then read 0x0060 → phys_write precedes phys_read; no forwarding.
